// File: rtl/usb_fifo_pkg.sv
// usb_fifo_pkg: state encoding and client indices shared by the USB FIFO arbiter
package usb_fifo_pkg;
  typedef enum logic [2:0] {IDLE, RD_LOW, RD_HIGH, WR_HIGH, WR_LOW, TURN, SI_LOW, SI_HIGH} state_t;
  localparam logic [1:0] CLI_RX = 2'd0;
  localparam logic [1:0] CLI_TX0 = 2'd1;
  localparam logic [1:0] CLI_TX1 = 2'd2;
endpackage

// File: rtl/usb_fifo_arbiter_rr.sv
// rr_arb3: three-way round-robin arbiter, search starts after the last granted client
module rr_arb3
  import usb_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       advance,
  output logic [2:0] grant,
  output logic [1:0] ptr
);
  logic [1:0] ptr_q, ptr_d, p1, p2, gidx;
  always_comb begin
    p1 = ptr_q == CLI_TX1 ? CLI_RX : ptr_q + 2'd1;
    p2 = p1 == CLI_TX1 ? CLI_RX : p1 + 2'd1;
    gidx = req[ptr_q] ? ptr_q : req[p1] ? p1 : p2;
    grant = req[gidx] ? 3'b001 << gidx : 3'b000;
    ptr_d = advance && |req ? (gidx == CLI_TX1 ? CLI_RX : gidx + 2'd1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= CLI_RX;
    else ptr_q <= ptr_d;
  end
  assign ptr = ptr_q;
endmodule

// File: rtl/usb_fifo_arbiter.sv
// usb_fifo_arbiter: shares an FT245-style USB FIFO bus between one RX sink and two TX requesters
module usb_fifo_arbiter
  import usb_fifo_pkg::*;
#(
  parameter int PHASE_CYC = 4,
  parameter int TURN_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxf,
  input  logic       txe,
  output logic       rd,
  output logic       wr,
  inout  wire  [7:0] d,
  output logic       si,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx0_data,
  input  logic       tx0_req,
  output logic       tx0_ack,
  input  logic [7:0] tx1_data,
  input  logic       tx1_req,
  output logic       tx1_ack,
  input  logic       flush_req,
  output logic       busy
);
  localparam int CW = $clog2(PHASE_CYC + TURN_CYC + 1);
  localparam logic [CW-1:0] PH_LD = CW'(PHASE_CYC - 1);
  localparam logic [CW-1:0] TU_LD = CW'(TURN_CYC == 0 ? 0 : TURN_CYC - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] rx_data_q, rx_data_d, wdata_q, wdata_d;
  logic rx_valid_q, rx_valid_d, pend_q, pend_d;
  logic [2:0] elig, grant;
  logic [1:0] ptr;
  logic idle, last, si_go;
  assign elig = {tx1_req & ~txe, tx0_req & ~txe, ~rxf & rx_ready};
  assign idle = state_q == IDLE;
  assign last = cnt_q == '0;
  assign si_go = idle & ~|grant & pend_q & ~txe;
  rr_arb3 u_arb (
    .clk(clk),
    .rst(rst),
    .req(elig),
    .advance(idle),
    .grant(grant),
    .ptr(ptr)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = last ? cnt_q : cnt_q - 1'b1;
    wdata_d = wdata_q;
    rx_valid_d = state_q == RD_LOW && last;
    rx_data_d = rx_valid_d ? d : rx_data_q;
    pend_d = flush_req | (pend_q & ~si_go);
    case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d = grant[0] ? RD_LOW : WR_HIGH;
          cnt_d = PH_LD;
          wdata_d = grant[1] ? tx0_data : grant[2] ? tx1_data : wdata_q;
        end else if (si_go) begin
          state_d = SI_LOW;
          cnt_d = PH_LD;
        end
      end
      RD_LOW: if (last) begin
        state_d = RD_HIGH;
        cnt_d = PH_LD;
      end
      WR_HIGH: if (last) begin
        state_d = WR_LOW;
        cnt_d = PH_LD;
      end
      WR_LOW: if (last) begin
        state_d = TURN_CYC == 0 ? IDLE : TURN;
        cnt_d = TU_LD;
      end
      SI_LOW: if (last) begin
        state_d = SI_HIGH;
        cnt_d = PH_LD;
      end
      RD_HIGH, TURN, SI_HIGH: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rx_data_q <= '0;
      wdata_q <= '0;
      rx_valid_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rx_data_q <= rx_data_d;
      wdata_q <= wdata_d;
      rx_valid_q <= rx_valid_d;
      pend_q <= pend_d;
    end
  end
  assign rd = state_q != RD_LOW;
  assign wr = state_q == WR_HIGH;
  assign si = state_q != SI_LOW;
  assign busy = !idle;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx0_ack = state_q == WR_HIGH && cnt_q == PH_LD && ptr == CLI_TX1;
  assign tx1_ack = state_q == WR_HIGH && cnt_q == PH_LD && ptr == CLI_RX;
  assign d = (state_q == WR_HIGH || state_q == WR_LOW) ? wdata_q : 8'bz;
endmodule

// File: tb/tb_usb_fifo_arbiter.sv
// tb_usb_fifo_arbiter: scenario tasks plus a randomized run against a transaction-level bus model
module tb_usb_fifo_arbiter;
  localparam int P = 4;
  localparam int T = 1;
  logic clk = 1'b0;
  logic rst, rxf, txe, rx_ready, tx0_req, tx1_req, flush_req;
  logic [7:0] tx0_data, tx1_data, d_tb, rx_data;
  logic rd, wr, si, rx_valid, tx0_ack, tx1_ack, busy;
  wire [7:0] d;
  assign d = rd ? 8'bz : d_tb;
  always #5 clk = ~clk;
  usb_fifo_arbiter #(.PHASE_CYC(P), .TURN_CYC(T)) dut (
    .clk(clk), .rst(rst), .rxf(rxf), .txe(txe), .rd(rd), .wr(wr), .d(d), .si(si),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx0_data(tx0_data), .tx0_req(tx0_req), .tx0_ack(tx0_ack),
    .tx1_data(tx1_data), .tx1_req(tx1_req), .tx1_ack(tx1_ack),
    .flush_req(flush_req), .busy(busy)
  );
  int errors = 0, checks = 0, cyc = 0;
  int m_kind = 0, m_k = 0, m_len = 0, m_ptr = 0, m_wcli = 0;
  bit m_pend = 1'b0;
  logic [7:0] m_wbyte = '0, m_rx = '0;
  logic e_rd, e_wr, e_si, e_busy, e_rxv, e_ack0, e_ack1, e_drv;
  task automatic tick();
    logic [2:0] el;
    bit go;
    int c;
    if (rst) begin
      m_kind = 0;
      m_k = 0;
      m_ptr = 0;
      m_pend = 1'b0;
      m_rx = '0;
    end else begin
      go = 1'b0;
      if (m_kind != 0) begin
        if (m_kind == 1 && m_k == P - 1) m_rx = d_tb;
        if (m_k == m_len - 1) m_kind = 0;
        else m_k++;
      end else begin
        el = {tx1_req && !txe, tx0_req && !txe, !rxf && rx_ready};
        for (int i = 0; i < 3; i++) begin
          c = (m_ptr + i) % 3;
          if (!go && el[c]) begin
            go = 1'b1;
            m_kind = c == 0 ? 1 : 2;
            m_k = 0;
            m_len = c == 0 ? 2 * P : 2 * P + T;
            m_wcli = c;
            m_wbyte = c == 1 ? tx0_data : tx1_data;
            m_ptr = (c + 1) % 3;
          end
        end
        if (!go && m_pend && !txe) begin
          m_kind = 3;
          m_k = 0;
          m_len = 2 * P;
          m_pend = 1'b0;
        end
      end
      m_pend = m_pend | flush_req;
    end
    @(posedge clk);
    #1;
    cyc++;
    e_busy = m_kind != 0;
    e_rd = !(m_kind == 1 && m_k < P);
    e_rxv = m_kind == 1 && m_k == P;
    e_wr = m_kind == 2 && m_k < P;
    e_drv = m_kind == 2 && m_k < 2 * P;
    e_ack0 = m_kind == 2 && m_k == 0 && m_wcli == 1;
    e_ack1 = m_kind == 2 && m_k == 0 && m_wcli == 2;
    e_si = !(m_kind == 3 && m_k < P);
  endtask
  task automatic set_idle();
    rxf = 1'b1;
    txe = 1'b1;
    rx_ready = 1'b0;
    tx0_req = 1'b0;
    tx1_req = 1'b0;
    flush_req = 1'b0;
  endtask
  task automatic drain();
    set_idle();
    for (int i = 0; i < 60 && busy !== 1'b0; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout busy=%b want 0", busy);
    end
    tick();
  endtask
  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({rd, wr, si, busy, rx_valid, tx0_ack, tx1_ack, rx_data} !== {7'b1010000, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", {rd, wr, si, busy, rx_valid, tx0_ack, tx1_ack, rx_data}, {7'b1010000, 8'h00});
    end
    tick();
    checks++;
    if ({rd, wr, si, busy} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_idle got %b want 1010", {rd, wr, si, busy});
    end
  endtask
  task automatic test_single_read();
    int lo = 0, pulses = 0;
    logic [7:0] got = '0;
    set_idle();
    d_tb = 8'hA5;
    rxf = 1'b0;
    rx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      rxf = 1'b1;
      rx_ready = 1'b0;
      if (!rd) lo++;
      if (rx_valid) begin
        pulses++;
        got = rx_data;
      end
      checks++;
      if (rd !== e_rd || rx_valid !== e_rxv) begin
        errors++;
        $display("FAIL read_wave cyc=%0d rd=%b rx_valid=%b want %b %b", i, rd, rx_valid, e_rd, e_rxv);
      end
    end
    checks++;
    if (lo != P || pulses != 1 || got !== 8'hA5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL read_summary rd_low=%0d pulses=%0d data=%h busy=%b want %0d 1 a5 0", lo, pulses, got, busy, P);
    end
  endtask
  task automatic test_round_robin();
    int order[$];
    logic prd = 1'b1, pwr = 1'b0;
    int exp_order[4] = '{0, 1, 2, 0};
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d_tb = 8'h5A;
    rxf = 1'b0;
    rx_ready = 1'b1;
    txe = 1'b0;
    tx0_req = 1'b1;
    tx0_data = 8'h11;
    tx1_req = 1'b1;
    tx1_data = 8'h22;
    for (int i = 0; i < 80 && order.size() < 4; i++) begin
      tick();
      if (prd && !rd) order.push_back(0);
      if (!pwr && wr) order.push_back(d === 8'h11 ? 1 : d === 8'h22 ? 2 : 9);
      prd = rd;
      pwr = wr;
      checks++;
      if (tx0_ack !== e_ack0 || tx1_ack !== e_ack1 || (e_drv && d !== m_wbyte)) begin
        errors++;
        $display("FAIL rr_ack_data ack0=%b ack1=%b d=%h want %b %b %h", tx0_ack, tx1_ack, d, e_ack0, e_ack1, m_wbyte);
      end
    end
    checks++;
    if (order.size() != 4) begin
      errors++;
      $display("FAIL rr_count got %0d services want 4", order.size());
    end
    for (int i = 0; i < order.size() && i < 4; i++) begin
      checks++;
      if (order[i] != exp_order[i]) begin
        errors++;
        $display("FAIL rr_order slot=%0d got %0d want %0d", i, order[i], exp_order[i]);
      end
    end
    drain();
  endtask
  task automatic test_turnaround();
    int t_w = -1, t_r = -1;
    set_idle();
    txe = 1'b0;
    tx0_req = 1'b1;
    tx0_data = 8'h3C;
    d_tb = 8'hC3;
    tick();
    tx0_req = 1'b0;
    rxf = 1'b0;
    rx_ready = 1'b1;
    if (wr) t_w = cyc;
    for (int i = 0; i < 40 && t_r < 0; i++) begin
      checks++;
      if ((!rd && wr) || (e_drv && d !== 8'h3C)) begin
        errors++;
        $display("FAIL turn_bus rd=%b wr=%b d=%h want no overlap, d=3c", rd, wr, d);
      end
      tick();
      if (wr && t_w < 0) t_w = cyc;
      if (!rd) begin
        t_r = cyc;
        rxf = 1'b1;
        rx_ready = 1'b0;
      end
    end
    checks++;
    if (t_w < 0 || t_r < 0 || t_r - t_w != 2 * P + T + 1) begin
      errors++;
      $display("FAIL turn_gap wr_start=%0d rd_fall=%0d want distance %0d", t_w, t_r, 2 * P + T + 1);
    end
    drain();
  endtask
  task automatic test_flush();
    int acks = 0, si_lo = 0, si_falls = 0, t_wfall = -1, t_si = -1;
    logic psi = 1'b1, pwr = 1'b0;
    set_idle();
    txe = 1'b0;
    tx0_req = 1'b1;
    tx0_data = 8'h77;
    flush_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      tx0_req = 1'b0;
      flush_req = i == 3;
      if (tx0_ack) acks++;
      if (!si) si_lo++;
      if (psi && !si) begin
        si_falls++;
        if (t_si < 0) t_si = cyc;
      end
      if (pwr && !wr && t_wfall < 0) t_wfall = cyc;
      psi = si;
      pwr = wr;
      checks++;
      if (si !== e_si) begin
        errors++;
        $display("FAIL flush_si cyc=%0d got %b want %b", i, si, e_si);
      end
    end
    checks++;
    if (acks != 1 || si_lo != P || si_falls != 1 || t_wfall < 0 || t_si <= t_wfall) begin
      errors++;
      $display("FAIL flush_order acks=%0d si_low=%0d si_pulses=%0d wr_fall=%0d si_fall=%0d want 1 %0d 1 wr_fall<si_fall", acks, si_lo, si_falls, t_wfall, t_si, P);
    end
    drain();
  endtask
  task automatic test_backpressure();
    set_idle();
    rxf = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (rd !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold rd=%b busy=%b want 1 0", rd, busy);
      end
    end
    rx_ready = 1'b1;
    tick();
    checks++;
    if (rd !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release rd=%b want 0", rd);
    end
    drain();
  endtask
  task automatic test_reset_mid_write();
    set_idle();
    txe = 1'b0;
    tx0_req = 1'b1;
    tx0_data = 8'h99;
    tick();
    tx0_req = 1'b0;
    checks++;
    if (wr !== 1'b1 || tx0_ack !== 1'b1 || d !== 8'h99) begin
      errors++;
      $display("FAIL midrst_start wr=%b ack=%b d=%h want 1 1 99", wr, tx0_ack, d);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({wr, rd, si, busy, tx0_ack} !== 5'b01100) begin
      errors++;
      $display("FAIL midrst_release got %b want 01100", {wr, rd, si, busy, tx0_ack});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (tx0_ack !== 1'b0 || wr !== 1'b0) begin
        errors++;
        $display("FAIL midrst_after ack=%b wr=%b want 0 0", tx0_ack, wr);
      end
    end
    drain();
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 399) == 0;
      rxf = $urandom_range(0, 2) == 0;
      txe = $urandom_range(0, 3) == 0;
      rx_ready = 1'($urandom_range(0, 1));
      tx0_req = 1'($urandom_range(0, 1));
      tx1_req = 1'($urandom_range(0, 1));
      tx0_data = 8'($urandom);
      tx1_data = 8'($urandom);
      d_tb = 8'($urandom);
      flush_req = $urandom_range(0, 15) == 0;
      tick();
      checks++;
      if ({rd, wr, si, busy, rx_valid, tx0_ack, tx1_ack} !== {e_rd, e_wr, e_si, e_busy, e_rxv, e_ack0, e_ack1}) begin
        errors++;
        $display("FAIL rand_ctrl cyc=%0d got %b want %b", i, {rd, wr, si, busy, rx_valid, tx0_ack, tx1_ack}, {e_rd, e_wr, e_si, e_busy, e_rxv, e_ack0, e_ack1});
      end
      checks++;
      if (rx_data !== m_rx || (e_drv && d !== m_wbyte)) begin
        errors++;
        $display("FAIL rand_data cyc=%0d rx_data=%h d=%h want %h %h", i, rx_data, d, m_rx, m_wbyte);
      end
    end
    rst = 1'b0;
    drain();
  endtask
  initial begin
    set_idle();
    rst = 1'b1;
    tx0_data = '0;
    tx1_data = '0;
    d_tb = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_turnaround();
    test_flush();
    test_backpressure();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usb_fifo_arbiter.md
Name: usb_fifo_arbiter

Overview:
Shares the FT245-style USB FIFO parallel bus (rxf/txe/rd/wr/d/si) among three clients: one host-to-FPGA receive sink and two FPGA-to-host transmit requesters (command responses, waveform readback). It round-robins bus cycles, times every strobe phase with a programmable cycle count, and owns tri-state control of d. It also issues send-immediate (si) flushes on request. It sits between the USB FIFO pins and the AWG command/readback logic.

Parameters:
PHASE_CYC, 4, clk cycles per strobe phase (>=1); sets rd/wr/si low and high widths
TURN_CYC, 1, idle clk cycles after any write before d may be read again (>=0)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rxf  in  1  FIFO has data, active-low
txe  in  1  FIFO has space, active-low
rd  out  1  read strobe, active-low
wr  out  1  write strobe, active-high; FIFO latches on the falling edge
d  inout  8  FIFO data bus
si  out  1  send-immediate, active-low
rx_data  out  8  received byte
rx_valid  out  1  one-cycle pulse; rx_data valid
rx_ready  in  1  sink can accept a byte
tx0_data  in  8  requester 0 byte
tx0_req  in  1  requester 0 wants to write
tx0_ack  out  1  one-cycle pulse; tx0_data captured
tx1_data  in  8  requester 1 byte
tx1_req  in  1  requester 1 wants to write
tx1_ack  out  1  one-cycle pulse; tx1_data captured
flush_req  in  1  one-cycle pulse; request si flush
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: rd=1, wr=0, si=1, d=Z, rx_data=0, rx_valid=0, tx0_ack=0, tx1_ack=0, busy=0; state=IDLE, RR pointer=RX, flush pending=0, phase counter=0. Reset mid-cycle releases the bus on that edge; the partial transfer is abandoned with no ack and no rx_valid.
- Eligibility, evaluated in IDLE only: RX if rxf==0 && rx_ready; TXn if txn_req && txe==0.
- Arbitration: round-robin over RX→TX0→TX1. The search starts at the client after the last granted one. The grant is registered on the clk edge leaving IDLE.
- States, each timed phase lasting exactly PHASE_CYC cycles:
  IDLE → RD_LOW (rd=0) → RD_HIGH (rd=1) → IDLE.
  IDLE → WR_HIGH (wr=1, d driven) → WR_LOW (wr=0, d still driven) → TURN (TURN_CYC cycles, d=Z; skipped if TURN_CYC=0) → IDLE.
  IDLE → SI_LOW (si=0) → SI_HIGH → IDLE.
- Read: d is sampled on the last cycle of RD_LOW. rx_data is updated and rx_valid pulses for 1 cycle on the following cycle, which is the first cycle of RD_HIGH.
- Write: txn_data is latched into an internal register on the grant edge. txn_ack pulses in the first cycle of WR_HIGH. The requester may change data or drop req from the next cycle.
- d is driven only in WR_HIGH and WR_LOW; it is Z in all other states.
- Flush: a flush_req pulse sets the pending flag. A flush_req while the flag is already set merges into it. SI is served from IDLE only when the flag is set, txe==0, and no TX is eligible, so queued bytes precede the flush. The flag clears on entry to SI_LOW.
- Committed transfers always complete: rxf rising during RD_*, txe rising during WR_*, req dropping after grant, and rx_ready falling after grant have no effect on the transfer in progress.
- If req drops before the grant, no write and no ack occur.
- With nothing eligible, the block stays in IDLE.
- Throughput: one byte per 2*PHASE_CYC cycles for reads and 2*PHASE_CYC+TURN_CYC cycles for writes, plus 1 IDLE cycle each.
- The phase counter is $clog2(PHASE_CYC+TURN_CYC+1) bits wide, counts down, and reloads on every state entry.

Decomposition:
- Package usb_fifo_pkg: state encoding (IDLE, RD_LOW, RD_HIGH, WR_HIGH, WR_LOW, TURN, SI_LOW, SI_HIGH) and client indices (CLI_RX=0, CLI_TX0=1, CLI_TX1=2).
- Sub-module rr_arb3: 3-way round-robin. Inputs: req[2:0], advance. Outputs: one-hot grant and pointer.
- The top level holds the FSM, phase counter, data registers and tri-state control.

Test Plan:
- Reset mid-write (PHASE_CYC=4): rst asserted in cycle 2 of WR_HIGH → next cycle wr=0, d=Z, rd=1, si=1, no tx0_ack re-pulse, busy=0.
- Single read: rxf=0, rx_ready=1, d=8'hA5 → rd low exactly 4 cycles; rx_valid 1-cycle pulse with rx_data=8'hA5; rd high 4 cycles; back to IDLE.
- Round-robin: rxf=0, tx0_req=1 (8'h11), tx1_req=1 (8'h22), txe=0 continuously, pointer at reset → service order RX, TX0, TX1, RX. The bus carries 8'h11 then 8'h22. Each ack is a 1-cycle pulse.
- Turnaround: a write of 8'h3C followed by a pending read with TURN_CYC=1 → d is Z for at least 1 cycle before rd falls, with no cycle where the block drives d while rd=0.
- Flush ordering: flush_req pulsed while tx0_req is high → the byte write completes first, then si is low exactly 4 cycles. A second flush_req during the write produces only one si pulse.
- Backpressure: rxf=0, rx_ready=0, txe=1 → rd stays 1, busy=0 indefinitely. Raising rx_ready starts a read on the following cycle.
